// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode, SIGNAL bit index and width constants for the calculator datapath
package calc_pkg;

  localparam int FCT_WIDTH = 3;
  localparam int SIG_WIDTH = 4;

  localparam logic [FCT_WIDTH-1:0] OP_ADD = 3'd0;
  localparam logic [FCT_WIDTH-1:0] OP_SUB = 3'd1;
  localparam logic [FCT_WIDTH-1:0] OP_AND = 3'd2;
  localparam logic [FCT_WIDTH-1:0] OP_OR  = 3'd3;
  localparam logic [FCT_WIDTH-1:0] OP_XOR = 3'd4;
  localparam logic [FCT_WIDTH-1:0] OP_MUL = 3'd5;
  localparam logic [FCT_WIDTH-1:0] OP_DIV = 3'd6;
  localparam logic [FCT_WIDTH-1:0] OP_MOD = 3'd7;

  localparam int SIG_ZERO = 0;
  localparam int SIG_NEG  = 1;
  localparam int SIG_DBZ  = 2;
  localparam int SIG_OVF  = 3;

  function automatic logic is_iter_op(input logic [FCT_WIDTH-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// rtl/calc_iter_unit.sv - iterative shift-add multiplier / restoring divider for MUL, DIV and MOD
// Build option CALC_SIGNED_EN: iterates on magnitudes, then one fix-up cycle restores signs.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start,
  input  logic                 abort,
  input  logic [FCT_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 valid,
  output logic [WIDTH-1:0]     result,
  output logic                 ovf,
  output logic                 dbz
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef CALC_SIGNED_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

  logic                 r_busy;
  logic                 r_dbz;
  logic [CW-1:0]        r_cnt;
  logic [FCT_WIDTH-1:0] r_op;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_hi_nx;
  logic [WIDTH-1:0]     w_lo_nx;
  logic [WIDTH-1:0]     w_fin_hi;
  logic [WIDTH-1:0]     w_fin_lo;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_trial;

`ifdef CALC_SIGNED_EN
  logic r_neg;
  assign w_mag_a  = a[WIDTH-1] ? -a : a;
  assign w_mag_b  = b[WIDTH-1] ? -b : b;
  assign w_fin_hi = r_hi;
  assign w_fin_lo = r_lo;
`else
  assign w_mag_a  = a;
  assign w_mag_b  = b;
  // Unsigned results come straight off the last iteration so S lands WIDTH edges after launch.
  assign w_fin_hi = w_hi_nx;
  assign w_fin_lo = w_lo_nx;
`endif

  assign busy     = r_busy;
  assign valid    = r_busy && (r_cnt == LAST);
  assign dbz      = r_dbz;
  assign w_addend = r_lo[0] ? r_b : '0;

  // {r_hi, r_lo} is the product pair for MUL and the {remainder, quotient} pair for DIV/MOD.
  always_comb begin
    w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_b};
    if (r_op == OP_MUL) begin
      w_hi_nx = w_sum[WIDTH:1];
      w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_trial[WIDTH]) begin
      w_hi_nx = w_trial[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_nx = w_rem_sh[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    result = w_fin_lo;
    ovf    = 1'b0;
`ifdef CALC_SIGNED_EN
    case (r_op)
      OP_MUL: begin
        result = r_neg ? -w_fin_lo : w_fin_lo;
        ovf    = (|w_fin_hi) || (w_fin_lo[WIDTH-1] && (!r_neg || (|w_fin_lo[WIDTH-2:0])));
      end
      OP_MOD: result = r_neg ? -w_fin_hi : w_fin_hi;
      default: begin
        if (r_dbz) begin
          result = '1;
        end else begin
          result = r_neg ? -w_fin_lo : w_fin_lo;
          ovf    = !r_neg && w_fin_lo[WIDTH-1];
        end
      end
    endcase
`else
    case (r_op)
      OP_MUL:  ovf = |w_fin_hi;
      OP_MOD:  result = w_fin_hi;
      default: result = w_fin_lo;
    endcase
`endif
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_busy <= 1'b0;
      r_dbz  <= 1'b0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
`ifdef CALC_SIGNED_EN
      r_neg  <= 1'b0;
`endif
    end else if (abort) begin
      r_busy <= 1'b0;
    end else if (start && !r_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_op   <= op;
      r_hi   <= '0;
      r_lo   <= w_mag_a;
      r_b    <= w_mag_b;
      r_dbz  <= (op != OP_MUL) && (b == '0);
`ifdef CALC_SIGNED_EN
      r_neg  <= (op == OP_MOD) ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
    end else if (r_busy) begin
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/calc_datapath.sv
// rtl/calc_datapath.sv - calculator A/B/FCT/S/SIGNAL registers, single-cycle ALU and done generation
// Build option CALC_SIGNED_EN: two's complement operands; iterative ops take WIDTH+1 cycles.
module calc_datapath #(
  parameter int WIDTH     = 8,
  parameter int FCT_WIDTH = calc_pkg::FCT_WIDTH
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 a_we_i,
  input  logic                 a_rst_i,
  input  logic                 b_we_i,
  input  logic                 b_rst_i,
  input  logic                 fct_we_i,
  input  logic                 fct_rst_i,
  input  logic                 s_we_i,
  input  logic                 s_rst_i,
  input  logic                 signal_we_i,
  input  logic                 signal_rst_i,
  input  logic [WIDTH-1:0]     a_data_i,
  input  logic [WIDTH-1:0]     b_data_i,
  input  logic [FCT_WIDTH-1:0] fct_data_i,
  output logic [WIDTH-1:0]     s_o,
  output logic [3:0]           signal_o,
  output logic                 busy_o,
  output logic                 done_o
);
  import calc_pkg::*;

  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_s;
  logic [FCT_WIDTH-1:0] r_fct;
  logic [3:0]           r_signal;
  logic                 r_done;
  logic                 r_sig_pend;
  logic [WIDTH-1:0]     w_alu;
  logic [WIDTH-1:0]     w_iter_res;
  logic [3:0]           w_alu_sig;
  logic [3:0]           w_iter_sig;
  logic                 w_carry;
  logic                 w_alu_ovf;
  logic                 w_is_iter;
  logic                 w_launch;
  logic                 w_busy;
  logic                 w_valid;
  logic                 w_iter_ovf;
  logic                 w_iter_dbz;

  assign w_is_iter = is_iter_op(r_fct);
  assign w_launch  = s_we_i && !s_rst_i && !w_busy;

  calc_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start   (w_launch && w_is_iter),
    .abort   (s_rst_i),
    .op      (r_fct),
    .a       (r_a),
    .b       (r_b),
    .busy    (w_busy),
    .valid   (w_valid),
    .result  (w_iter_res),
    .ovf     (w_iter_ovf),
    .dbz     (w_iter_dbz)
  );

  always_comb begin
    w_carry = 1'b0;
    w_alu   = '0;
    case (r_fct)
      OP_ADD:  {w_carry, w_alu} = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB:  {w_carry, w_alu} = {1'b0, r_a} - {1'b0, r_b};
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      default: w_alu = '0;
    endcase
`ifdef CALC_SIGNED_EN
    // Carry into the MSB differs from carry out exactly on signed overflow, for ADD and SUB alike.
    w_alu_ovf = ((r_fct == OP_ADD) || (r_fct == OP_SUB)) &&
                (w_carry ^ r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_alu[WIDTH-1]);
`else
    w_alu_ovf = w_carry;
`endif
    w_alu_sig            = '0;
    w_alu_sig[SIG_OVF]   = w_alu_ovf;
    w_alu_sig[SIG_NEG]   = w_alu[WIDTH-1];
    w_alu_sig[SIG_ZERO]  = (w_alu == '0);
    w_iter_sig           = '0;
    w_iter_sig[SIG_OVF]  = w_iter_ovf;
    w_iter_sig[SIG_DBZ]  = w_iter_dbz;
    w_iter_sig[SIG_NEG]  = w_iter_res[WIDTH-1];
    w_iter_sig[SIG_ZERO] = (w_iter_res == '0);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_a        <= '0;
      r_b        <= '0;
      r_fct      <= '0;
      r_s        <= '0;
      r_signal   <= '0;
      r_done     <= 1'b0;
      r_sig_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (a_rst_i)        r_a <= '0;
      else if (a_we_i)    r_a <= a_data_i;
      if (b_rst_i)        r_b <= '0;
      else if (b_we_i)    r_b <= b_data_i;
      if (fct_rst_i)      r_fct <= '0;
      else if (fct_we_i)  r_fct <= fct_data_i;

      if (s_rst_i) begin
        r_s <= '0;
      end else if (w_launch && !w_is_iter) begin
        r_s    <= w_alu;
        r_done <= 1'b1;
      end else if (w_valid) begin
        r_s    <= w_iter_res;
        r_done <= 1'b1;
      end

      if (w_launch && w_is_iter) r_sig_pend <= signal_we_i;

      // An aborted operation never reaches SIGNAL.
      if (signal_rst_i)                                        r_signal <= '0;
      else if (w_launch && !w_is_iter && signal_we_i)           r_signal <= w_alu_sig;
      else if (!s_rst_i && w_valid && r_sig_pend)               r_signal <= w_iter_sig;
    end
  end

  assign s_o      = r_s;
  assign signal_o = r_signal;
  assign busy_o   = w_busy;
  assign done_o   = r_done;

endmodule

// File: tb/tb_calc_datapath.sv
// tb/tb_calc_datapath.sv - directed vector bench for calc_datapath (WIDTH=8)
module tb_calc_datapath;

  localparam int W = 8;
`ifdef CALC_SIGNED_EN
  localparam int ILAT = W + 1;
`else
  localparam int ILAT = W;
`endif
  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_XOR = 3'd4;
  localparam logic [2:0] F_MUL = 3'd5;
  localparam logic [2:0] F_DIV = 3'd6;
  localparam logic [2:0] F_MOD = 3'd7;
  localparam int NV = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_we = 0, a_rst = 0, b_we = 0, b_rst = 0, fct_we = 0, fct_rst = 0;
  logic         s_we = 0, s_rst = 0, signal_we = 0, signal_rst = 0;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic [2:0]   fct_data = '0;
  logic [W-1:0] s_o;
  logic [3:0]   signal_o;
  logic         busy_o, done_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] fct;
    logic       swe;
    logic [7:0] s;
    logic [3:0] sig;
    int         lat;
  } vec_t;

  vec_t vecs [NV];

  calc_datapath #(.WIDTH(W), .FCT_WIDTH(3)) dut (
    .clock_i(clk), .reset_i(rst),
    .a_we_i(a_we), .a_rst_i(a_rst), .b_we_i(b_we), .b_rst_i(b_rst),
    .fct_we_i(fct_we), .fct_rst_i(fct_rst), .s_we_i(s_we), .s_rst_i(s_rst),
    .signal_we_i(signal_we), .signal_rst_i(signal_rst),
    .a_data_i(a_data), .b_data_i(b_data), .fct_data_i(fct_data),
    .s_o(s_o), .signal_o(signal_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f, input logic swe);
    @(negedge clk);
    a_we = 1; b_we = 1; fct_we = 1; a_data = a; b_data = b; fct_data = f;
    @(negedge clk);
    a_we = 0; b_we = 0; fct_we = 0; s_we = 1; signal_we = swe;
    @(negedge clk);
    s_we = 0; signal_we = 0;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    while (done_o !== 1'b1 && lat < 50) begin
      if (busy_o === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic watch_idle(input string name, input int cycles);
    logic seen_done, seen_busy;
    seen_done = 0;
    seen_busy = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen_done = 1;
      if (busy_o !== 1'b0) seen_busy = 1;
    end
    chk({name, "_no_done"}, seen_done, 0);
    chk({name, "_no_busy"}, seen_busy, 0);
  endtask

  initial begin
    int lat, nb;

    repeat (2) @(negedge clk);
    chk("rst_s", s_o, 0);
    chk("rst_signal", signal_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst = 0;
    watch_idle("idle", 5);
    chk("idle_s", s_o, 0);
    chk("idle_signal", signal_o, 0);

`ifdef CALC_SIGNED_EN
    vecs[0]  = '{8'd100,  8'd100,  F_ADD, 1'b1, 8'hC8, 4'b1010, 0};
    vecs[1]  = '{8'hFF,   8'hFF,   F_ADD, 1'b1, 8'hFE, 4'b0010, 0};
    vecs[2]  = '{8'd100,  8'h9C,   F_SUB, 1'b1, 8'hC8, 4'b1010, 0};
    vecs[3]  = '{8'hF0,   8'h0F,   F_AND, 1'b0, 8'h00, 4'b1010, 0};
    vecs[4]  = '{8'hF9,   8'h02,   F_DIV, 1'b1, 8'hFD, 4'b0010, ILAT};
    vecs[5]  = '{8'hF9,   8'h02,   F_MOD, 1'b1, 8'hFF, 4'b0010, ILAT};
    vecs[6]  = '{8'h80,   8'hFF,   F_DIV, 1'b1, 8'h80, 4'b1010, ILAT};
    vecs[7]  = '{8'hFD,   8'h05,   F_MUL, 1'b1, 8'hF1, 4'b0010, ILAT};
    vecs[8]  = '{8'd20,   8'd13,   F_MUL, 1'b1, 8'h04, 4'b1000, ILAT};
    vecs[9]  = '{8'h07,   8'hFE,   F_DIV, 1'b0, 8'hFD, 4'b1000, ILAT};
    vecs[10] = '{8'h07,   8'hFE,   F_MOD, 1'b1, 8'h01, 4'b0000, ILAT};
    vecs[11] = '{8'd57,   8'h00,   F_DIV, 1'b1, 8'hFF, 4'b0110, ILAT};
    vecs[12] = '{8'hC7,   8'h00,   F_MOD, 1'b1, 8'hC7, 4'b0110, ILAT};
    vecs[13] = '{8'hA5,   8'h0F,   F_OR,  1'b1, 8'hAF, 4'b0010, 0};
`else
    vecs[0]  = '{8'd200,  8'd100,  F_ADD, 1'b1, 8'd44,  4'b1000, 0};
    vecs[1]  = '{8'd100,  8'd200,  F_SUB, 1'b1, 8'd156, 4'b1010, 0};
    vecs[2]  = '{8'hF0,   8'h0F,   F_AND, 1'b0, 8'h00,  4'b1010, 0};
    vecs[3]  = '{8'hA5,   8'h0F,   F_OR,  1'b1, 8'hAF,  4'b0010, 0};
    vecs[4]  = '{8'hFF,   8'hFF,   F_XOR, 1'b1, 8'h00,  4'b0001, 0};
    vecs[5]  = '{8'd15,   8'd17,   F_MUL, 1'b1, 8'hFF,  4'b0010, ILAT};
    vecs[6]  = '{8'd100,  8'd7,    F_DIV, 1'b0, 8'd14,  4'b0010, ILAT};
    vecs[7]  = '{8'd100,  8'd7,    F_MOD, 1'b1, 8'd2,   4'b0000, ILAT};
    vecs[8]  = '{8'd57,   8'd0,    F_DIV, 1'b1, 8'd255, 4'b0110, ILAT};
    vecs[9]  = '{8'd57,   8'd0,    F_MOD, 1'b1, 8'd57,  4'b0100, ILAT};
    vecs[10] = '{8'd7,    8'd200,  F_DIV, 1'b1, 8'd0,   4'b0001, ILAT};
    vecs[11] = '{8'd255,  8'd16,   F_MOD, 1'b1, 8'd15,  4'b0000, ILAT};
    vecs[12] = '{8'd255,  8'd1,    F_ADD, 1'b1, 8'd0,   4'b1001, 0};
    vecs[13] = '{8'd20,   8'd13,   F_MUL, 1'b1, 8'd4,   4'b1000, ILAT};
`endif

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].fct, vecs[i].swe);
      wait_done(lat, nb);
      chk($sformatf("v%0d_s", i), s_o, vecs[i].s);
      chk($sformatf("v%0d_signal", i), signal_o, vecs[i].sig);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), nb, vecs[i].lat);
      chk($sformatf("v%0d_busy_at_done", i), busy_o, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_1cyc", i), done_o, 0);
    end

    // MUL 20*13: A and FCT rewritten mid-flight plus a stray s_we while busy
    launch(8'd20, 8'd13, F_MUL, 1'b1);
    lat = 0;
    nb = 0;
    while (done_o !== 1'b1 && lat < 50) begin
      if (busy_o === 1'b1) nb++;
      a_we = (lat == 3);
      fct_we = (lat == 3);
      a_data = 8'd0;
      fct_data = F_AND;
      s_we = (lat == 5);
      @(negedge clk);
      lat++;
    end
    a_we = 0; fct_we = 0; s_we = 0;
    chk("mulbusy_s", s_o, 8'd4);
    chk("mulbusy_signal", signal_o, 4'b1000);
    chk("mulbusy_latency", lat, ILAT);
    chk("mulbusy_busy_cycles", nb, ILAT);
    @(negedge clk);
    chk("mulbusy_done_1cyc", done_o, 0);

    // DIV 100/7 aborted by s_rst at cycle 4, with an ignored s_we at cycle 2
    launch(8'd100, 8'd7, F_DIV, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        chk("abort_pre_s", s_o, 8'd4);
        chk("abort_pre_busy", busy_o, 1);
      end
      s_we = (k == 1);
      s_rst = (k == 3);
      @(negedge clk);
    end
    s_we = 0; s_rst = 0;
    chk("abort_s", s_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_signal", signal_o, 4'b1000);
    chk("abort_done", done_o, 0);
    watch_idle("abort", 12);

    // reset_i asserted mid-MUL clears everything at once
    launch(8'd200, 8'd100, F_ADD, 1'b1);
    launch(8'd20, 8'd13, F_MUL, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_pre_busy", busy_o, 1);
    chk("rstmid_pre_s", s_o, 8'd44);
    rst = 1;
    #1;
    chk("rstmid_s", s_o, 0);
    chk("rstmid_signal", signal_o, 0);
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_done", done_o, 0);
    @(negedge clk);
    rst = 0;
    watch_idle("rstmid", 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
